// File: rtl/grey_pkg.sv
// grey_pkg: shared defaults and helpers for the Gray-code pipeline.
//   DEFAULT_N      default code width (bits)
//   DEFAULT_ERR_W  default error-counter width (bits)
//   multi_bit_step returns 1 when two words differ in more than one bit
package grey_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_ERR_W = 8;

  // Words are zero-extended to 64 bits by the caller, so this covers any
  // code width up to 64. Clearing the lowest set bit of the difference
  // leaves a non-zero value only if at least two bits differ.
  function automatic logic multi_bit_step(input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] d;
    d = a ^ b;
    return (d & (d - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/grey_to_bin.sv
// grey_to_bin: purely combinational Gray-to-binary converter.
//   grey [N-1:0]  Gray-coded word (MSB = bit N-1)
//   bin  [N-1:0]  binary equivalent
module grey_to_bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] grey,
  output logic [N-1:0] bin
);

  // bin[i] = bin[i+1] ^ grey[i] unrolls to the XOR of all Gray bits from
  // the MSB down to i; writing it that way avoids a bit-to-bit chain
  // through the same vector.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign bin[gi] = ^grey[N-1:gi];
  end

endmodule

// File: rtl/grey_to_bin_pipe.sv
// grey_to_bin_pipe: single-stage valid/ready pipeline converting Gray words
// to binary, with a step checker that flags accepted words differing from
// the previously accepted word in more than one bit.
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_grey  [N-1:0]    Gray-coded input word
//   out_valid/out_ready downstream handshake
//   out_bin  [N-1:0]    converted binary word
//   step_err            one-cycle pulse aligned with the offending word
//   err_count[ERR_W-1:0] saturating count of step_err pulses
//   clear_err           synchronous clear of err_count and step history
module grey_to_bin_pipe
  import grey_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int ERR_W = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_grey,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_bin,
  input  logic             out_ready,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  input  logic             clear_err
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic             out_valid_reg, out_valid_next;
  logic [N-1:0]     out_bin_reg,   out_bin_next;
  logic             step_err_reg,  step_err_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic [N-1:0]     prev_grey_reg, prev_grey_next;
  logic             prev_valid_reg, prev_valid_next;

  logic [N-1:0]     bin_conv;
  logic             accept;
  logic             jump_err;

  grey_to_bin #(.N(N)) u_conv (
    .grey (in_grey),
    .bin  (bin_conv)
  );

  // The stage can take a word when it is empty or being drained this cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // An illegal step only counts when history is valid; a same-cycle clear
  // wipes history first, so that word is never flagged.
  assign jump_err = accept && prev_valid_reg && !clear_err &&
                    multi_bit_step(64'(in_grey), 64'(prev_grey_reg));

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_bin_next    = out_bin_reg;
    step_err_next   = jump_err;
    err_count_next  = err_count_reg;
    prev_grey_next  = prev_grey_reg;
    prev_valid_next = prev_valid_reg;

    // Load on accept (covers drain-and-refill with no bubble); otherwise a
    // drain empties the stage and a stall holds it.
    if (accept) begin
      out_valid_next = 1'b1;
      out_bin_next   = bin_conv;
      prev_grey_next = in_grey;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end

    if (clear_err) begin
      err_count_next  = '0;
      prev_valid_next = 1'b0;
    end else begin
      if (accept) begin
        prev_valid_next = 1'b1;
      end
      if (jump_err && err_count_reg != ERR_MAX) begin
        err_count_next = err_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_bin_reg    <= '0;
      step_err_reg   <= 1'b0;
      err_count_reg  <= '0;
      prev_grey_reg  <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_bin_reg    <= out_bin_next;
      step_err_reg   <= step_err_next;
      err_count_reg  <= err_count_next;
      prev_grey_reg  <= prev_grey_next;
      prev_valid_reg <= prev_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_bin   = out_bin_reg;
  assign step_err  = step_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_grey_to_bin_pipe.sv
// tb_grey_to_bin_pipe: directed, table-driven bench for grey_to_bin_pipe
// (N=4, ERR_W=8). Inputs change 1ns after each rising edge; outputs are
// sampled at that same point, i.e. well away from the active edge.
module tb_grey_to_bin_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_grey;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_ready;
  logic       step_err;
  logic [7:0] err_count;
  logic       clear_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] grey;
    logic [3:0] exp_bin;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  grey_to_bin_pipe #(.N(4), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_grey   (in_grey),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_ready (out_ready),
    .step_err  (step_err),
    .err_count (err_count),
    .clear_err (clear_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word with out_ready=1 and check the result one edge later.
  task automatic send(input logic [3:0] g, input logic clr,
                      input logic [3:0] eb, input logic ee, input logic [7:0] ec);
    in_valid  = 1'b1;
    in_grey   = g;
    out_ready = 1'b1;
    clear_err = clr;
    tick();
    $display("txn grey=%b clr=%b -> bin=%b step_err=%b cnt=%0d", g, clr, out_bin, step_err, err_count);
    chk("send_valid", {31'd0, out_valid}, 32'd1);
    chk("send_bin",   {28'd0, out_bin},   {28'd0, eb});
    chk("send_err",   {31'd0, step_err},  {31'd0, ee});
    chk("send_cnt",   {24'd0, err_count}, {24'd0, ec});
    clear_err = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    int         model_cnt;

    // Stream table: Gray in, binary out, expected step_err, expected count.
    vecs[0]  = '{4'b0000, 4'd0,  1'b0, 8'd0};
    vecs[1]  = '{4'b0001, 4'd1,  1'b0, 8'd0};
    vecs[2]  = '{4'b0011, 4'd2,  1'b0, 8'd0};
    vecs[3]  = '{4'b0010, 4'd3,  1'b0, 8'd0};
    vecs[4]  = '{4'b0110, 4'd4,  1'b0, 8'd0};
    vecs[5]  = '{4'b0111, 4'd5,  1'b0, 8'd0};
    vecs[6]  = '{4'b0101, 4'd6,  1'b0, 8'd0};
    vecs[7]  = '{4'b0100, 4'd7,  1'b0, 8'd0};
    vecs[8]  = '{4'b1100, 4'd8,  1'b0, 8'd0};
    vecs[9]  = '{4'b1111, 4'd10, 1'b1, 8'd1};  // 2-bit step
    vecs[10] = '{4'b1110, 4'd11, 1'b0, 8'd1};
    vecs[11] = '{4'b0001, 4'd1,  1'b1, 8'd2};  // 4-bit step
    vecs[12] = '{4'b0001, 4'd1,  1'b0, 8'd2};  // repeat: distance 0 is legal

    // Reset with in_valid held high: nothing may be captured.
    rst = 1'b1; in_valid = 1'b1; in_grey = 4'b0101; out_ready = 1'b1; clear_err = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bin",   {28'd0, out_bin},   32'd0);
    chk("rst_step_err",  {31'd0, step_err},  32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_in_ready2", {31'd0, in_ready},  32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream, including the bubble-free drain+refill.
    for (int i = 0; i < 13; i++) begin
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      send(vecs[i].grey, 1'b0, vecs[i].exp_bin, vecs[i].exp_err, vecs[i].exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_err",   {31'd0, step_err},  32'd0);

    // Backpressure: hold 0011 (bin 2) for 5 cycles with 0010 pending.
    in_valid = 1'b1; in_grey = 4'b0011; out_ready = 1'b0;
    tick();
    chk("bp_load_bin", {28'd0, out_bin}, 32'd2);
    in_grey = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      $display("txn stall cycle %0d: out_valid=%b out_bin=%b", i, out_valid, out_bin);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold",  {28'd0, out_bin},   32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_pending_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pending_bin",   {28'd0, out_bin},   32'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt",    {24'd0, err_count}, 32'd2);

    // Clear history/count, then 0001 -> 0111 jump.
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_cnt", {24'd0, err_count}, 32'd0);
    send(4'b0001, 1'b0, 4'd1, 1'b0, 8'd0);
    send(4'b0111, 1'b0, 4'b0101, 1'b1, 8'd1);
    in_valid = 1'b0;
    tick();
    chk("jump_pulse_end", {31'd0, step_err},  32'd0);
    chk("jump_cnt_hold",  {24'd0, err_count}, 32'd1);

    // 300 illegal jumps alternating 0000/1111: count saturates at 255.
    model_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      g = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      in_valid = 1'b1; in_grey = g; out_ready = 1'b1;
      tick();
      if (model_cnt < 255) model_cnt++;
      chk("sat_err", {31'd0, step_err},  32'd1);
      chk("sat_cnt", {24'd0, err_count}, model_cnt);
    end
    $display("txn saturation run done: cnt=%0d", err_count);

    // Last word was 1111; 0000 is illegal but the count stays saturated.
    send(4'b0000, 1'b0, 4'd0, 1'b1, 8'd255);
    // Clear in the same cycle as the 0000 -> 1111 jump.
    send(4'b1111, 1'b1, 4'b1010, 1'b0, 8'd0);
    send(4'b1110, 1'b0, 4'b1011, 1'b0, 8'd0);
    send(4'b0000, 1'b0, 4'd0,    1'b1, 8'd1);

    // Asynchronous reset mid-cycle while a word is stalled.
    send(4'b0001, 1'b0, 4'd1, 1'b0, 8'd1);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    chk("ar_stalled", {31'd0, out_valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    $display("txn async reset: out_valid=%b cnt=%0d", out_valid, err_count);
    chk("ar_valid_now", {31'd0, out_valid}, 32'd0);
    chk("ar_bin_now",   {28'd0, out_bin},   32'd0);
    chk("ar_cnt_now",   {24'd0, err_count}, 32'd0);
    chk("ar_ready_now", {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    tick();
    chk("ar_no_output", {31'd0, out_valid}, 32'd0);
    // First accept after reset is never flagged, but it does seed history.
    send(4'b1111, 1'b0, 4'b1010, 1'b0, 8'd0);
    send(4'b0000, 1'b0, 4'd0,    1'b1, 8'd1);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
